serv_seq: RTL
=============

# serv_seq

Fetch/execute sequencer for the bit-serial SERV core. Issues instruction-bus fetches, waits for the register file to be ready, then runs the 32-cycle serial execute pass that drives the PC/control datapath. It generates the bit-counter strobes (cnt0, cnt1, cnt2, cnt12to31) and the PC enable consumed by the serial PC logic. When misaligned-jump trapping is compiled in, it inserts a second 32-cycle trap pass.

## Interface
- COMPRESSED, 0: 1 = 16-bit instructions supported, so 2-byte jump targets are legal.
- clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_ibus_ack  in  1  instruction bus acknowledge; only meaningful while o_ibus_cyc=1
- i_rf_ready  in  1  register file ready to stream operands
- i_jump  in  1  current instruction takes a jump/branch (valid during RUN)
- i_bad_pc  in  1  serial aligned jump-target bit from PC datapath, LSB first
- o_ibus_cyc  out  1  fetch request
- o_rf_rreq  out  1  register-file read request
- o_pc_en  out  1  serial PC update enable
- o_cnt0, o_cnt1, o_cnt2  out  1 each  bit counter == 0 / 1 / 2, qualified by pass active
- o_cnt12to31  out  1  bit counter in 12..31, qualified by pass active
- o_cnt_done  out  1  bit counter == 31, qualified by pass active
- o_trap  out  1  trap pass active

## Operation
- State register with states IDLE, FETCH, DECODE, RUN, TRAP. There is a 5-bit bit counter `cnt` and a 1-bit misalign flag `mis`.
- IDLE (reset state) → FETCH unconditionally on the next clock.
- FETCH: o_ibus_cyc=1. On a cycle with i_ibus_ack=1, go to DECODE. Otherwise hold.
- DECODE: o_rf_rreq=1. On i_rf_ready=1, go to RUN with cnt=0. Otherwise hold indefinitely.
- RUN: o_pc_en=1. cnt increments by 1 each cycle, wrapping 31→0. At cnt==31:
  - go to TRAP if mis=1 (macro enabled);
  - otherwise go to FETCH.
- TRAP: o_trap=1 and o_pc_en=1 for 32 cycles, cnt 0..31. At cnt==31, go to FETCH.
- Strobes o_cnt0/1/2/12to31/done are decoded combinationally from cnt, ANDed with (RUN or TRAP). They are 0 in IDLE/FETCH/DECODE.
- mis capture: set in RUN at cnt==1 when i_jump=1 and i_bad_pc=1 and COMPRESSED=0. It is never set when COMPRESSED=1. Cleared on entry to FETCH.
- Outputs are decoded from registered state/cnt only (Moore). No input-to-output combinational path.

## Timing
- Reset: state=IDLE, cnt=0, mis=0. All outputs 0 during and in the first cycle after reset.
- o_ibus_cyc first rises 1 cycle after i_rst deasserts. It falls the cycle after ack is sampled.
- Best-case instruction: FETCH(1, ack same cycle) + DECODE(1) + RUN(32) = 34 cycles. Add 32 for a trap.
- An ack while o_ibus_cyc=0 is ignored.
- Reset mid-pass (any state): the next cycle is IDLE with cnt=0 and mis=0. No further strobes are issued.
- i_bad_pc is sampled only at RUN cnt==1; other bits are ignored.
- cnt wraps only at pass end; it is never observable > 31.

## Configuration
- SERV_SEQ_MISALIGN_TRAP_EN defined: mis flag and TRAP state are present, as described above.
- Not defined: mis is tied 0, TRAP is unreachable, o_trap is constant 0, and RUN at cnt==31 always goes to FETCH.

## Test plan
- Reset release, ack held 1, rf_ready 1 → cyc high cycle 1, rreq cycle 2, pc_en cycles 3–34, cyc again cycle 35; cnt0 at cycle 3, cnt2 at 5, cnt12to31 cycles 15–34, done cycle 34.
- Ack delayed 5 cycles, rf_ready delayed 3 → cyc held 6 cycles, rreq held 4; RUN still exactly 32 cycles.
- Macro on, COMPRESSED=0, i_jump=1, i_bad_pc=1 at cnt1 → TRAP follows RUN with o_trap=1 for 32 cycles, then FETCH. Next instruction without jump → no trap.
- Same stimulus with COMPRESSED=1, or with the macro off → no trap and o_trap stays 0.
- i_rst asserted at RUN cnt==17 → next cycle all outputs 0, then IDLE→FETCH. mis is cleared, so no trap follows.
- Spurious i_ibus_ack during RUN → ignored; state sequence unchanged.

Source files
------------

// File: rtl/serv_seq_if.sv
// rtl/serv_seq_if.sv - Handshake and strobe bundle between serv_seq and the SERV datapath/buses
interface serv_seq_if;
    logic ibus_cyc;
    logic ibus_ack;
    logic rf_rreq;
    logic rf_ready;
    logic jump;
    logic bad_pc;
    logic pc_en;
    logic cnt0;
    logic cnt1;
    logic cnt2;
    logic cnt12to31;
    logic cnt_done;
    logic trap;

    modport master (
        output ibus_cyc, rf_rreq, pc_en, cnt0, cnt1, cnt2, cnt12to31, cnt_done, trap,
        input  ibus_ack, rf_ready, jump, bad_pc
    );

    modport slave (
        input  ibus_cyc, rf_rreq, pc_en, cnt0, cnt1, cnt2, cnt12to31, cnt_done, trap,
        output ibus_ack, rf_ready, jump, bad_pc
    );
endinterface

// File: rtl/serv_seq.sv
// rtl/serv_seq.sv - SERV fetch/decode/execute sequencer; SERV_SEQ_MISALIGN_TRAP_EN adds the trap pass
module serv_seq #(
    parameter bit COMPRESSED = 1'b0
) (
    input  logic          clk,
    input  logic          i_rst,
    serv_seq_if.master    bus
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, RUN, TRAP} state_t;

    state_t     state;
    logic [4:0] cnt;
    logic       mis;
    logic       active;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            case (state)
                IDLE:   state <= FETCH;
                FETCH:  if (bus.ibus_ack) state <= DECODE;
                DECODE: if (bus.rf_ready) begin
                    state <= RUN;
                    cnt   <= 5'd0;
                end
                RUN: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= mis ? TRAP : FETCH;
                end
`ifdef SERV_SEQ_MISALIGN_TRAP_EN
                TRAP: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FETCH;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SERV_SEQ_MISALIGN_TRAP_EN
    // Only bit 1 of the target matters: bit 0 is always cleared by the PC datapath.
    always_ff @(posedge clk) begin
        if (i_rst || state == FETCH)
            mis <= 1'b0;
        else if (state == RUN && cnt == 5'd1 && bus.jump && bus.bad_pc && !COMPRESSED)
            mis <= 1'b1;
    end
    assign bus.trap = (state == TRAP);
`else
    logic unused_cfg;
    assign mis        = 1'b0;
    assign bus.trap   = 1'b0;
    assign unused_cfg = ^{bus.jump, bus.bad_pc, COMPRESSED};
`endif

    assign active        = (state == RUN) || (state == TRAP);
    assign bus.ibus_cyc  = (state == FETCH);
    assign bus.rf_rreq   = (state == DECODE);
    assign bus.pc_en     = active;
    assign bus.cnt0      = active && (cnt == 5'd0);
    assign bus.cnt1      = active && (cnt == 5'd1);
    assign bus.cnt2      = active && (cnt == 5'd2);
    assign bus.cnt12to31 = active && (cnt >= 5'd12);
    assign bus.cnt_done  = active && (cnt == 5'd31);
endmodule
